// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmitter.
//   - default parallel word width
//   - FSM state encoding (IDLE=0, SHIFT=1)
//   - bit-cell next-value select encoding
//   - constant function giving the bit-counter width for a word width
package piso_pkg;

  localparam int unsigned PISO_WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  typedef enum logic [1:0] {
    CELL_HOLD  = 2'd0,
    CELL_LOAD  = 2'd1,
    CELL_SHIFT = 2'd2
  } cell_sel_e;

  // ceil(log2(width)), never less than 1 so the counter always exists.
  function automatic int unsigned piso_cnt_width(input int unsigned width);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < width) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/piso_bit_cell.sv
// One bit of the PISO shift register.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears the cell
//   sel       next-value select: hold, parallel load, or shift-in
//   load_bit  value taken on a parallel load
//   shift_bit value taken from the neighbouring cell on a shift
//   q         stored bit
module piso_bit_cell
  import piso_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  cell_sel_e sel,
  input  logic      load_bit,
  input  logic      shift_bit,
  output logic      q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    unique case (sel)
      CELL_LOAD:  q_d = load_bit;
      CELL_SHIFT: q_d = shift_bit;
      default:    q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/piso_4bit_tx.sv
// Parallel-in serial-out transmitter.
// A word on D is captured when load is accepted (load=1 while ready=1) and
// sent one bit per cycle starting the cycle after the accepting edge, LSB or
// MSB first. A new load may be accepted during the final bit so frames can
// run back to back.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, aborts any frame
//   D          parallel word, sampled only on an accepted load
//   load       request to start a frame
//   ready      combinational: load will be accepted this cycle
//   sout       serial data bit (0 when idle)
//   sout_valid sout carries a frame bit
//   last       sout is the final bit of the frame
module piso_4bit_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH_DEFAULT,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

  localparam int unsigned      CW       = piso_cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  piso_state_e      state_d, state_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             last_d, last_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] shift_in;
  cell_sel_e        cell_sel;
  logic             accept;

  assign ready = (state_q == IDLE) || last_q;

  always_comb begin
    accept   = load && ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    cell_sel = CELL_HOLD;
    if (accept) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      cell_sel = CELL_LOAD;
    end else if (state_q == SHIFT) begin
      cell_sel = CELL_SHIFT;
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    last_d = (state_d == SHIFT) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Zeros shift in behind the data, so after the final bit the register is
  // empty and sout reads 0 in IDLE without extra gating.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign shift_in = {1'b0, sreg_q[WIDTH-1:1]};
      assign sout     = sreg_q[0];
    end else begin : g_msb
      assign shift_in = {sreg_q[WIDTH-2:0], 1'b0};
      assign sout     = sreg_q[WIDTH-1];
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    piso_bit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .sel      (cell_sel),
      .load_bit (D[i]),
      .shift_bit(shift_in[i]),
      .q        (sreg_q[i])
    );
  end

  assign sout_valid = (state_q == SHIFT);
  assign last       = last_q;

endmodule

// File: tb/tb_piso_4bit_tx.sv
module tb_piso_4bit_tx;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] D;

  logic ready_l, sout_l, valid_l, last_l;
  logic ready_m, sout_m, valid_m, last_m;

  always #5 clk = ~clk;

  piso_4bit_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .D(D), .load(load),
    .ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .last(last_l)
  );

  piso_4bit_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .D(D), .load(load),
    .ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .last(last_m)
  );

  typedef struct {
    logic sout;
    logic last;
    int   stamp;
  } exp_t;

  exp_t exp_q[2][$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rem      = 0;   // frame bits still to be shown, incl. current one
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Apply inputs for one cycle and advance the reference model at the edge.
  task automatic drive(input logic r, input logic l, input logic [W-1:0] d);
    bit acc;
    rst  = r;
    load = l;
    D    = d;
    @(posedge clk);
    cyc++;
    acc = l && !r && (rem <= 1);
    if (r) begin
      rem = 0;
      for (int k = 0; k < 2; k++) begin
        while (exp_q[k].size() > 0 && exp_q[k][$].stamp >= cyc) void'(exp_q[k].pop_back());
      end
    end else if (acc) begin
      for (int unsigned i = 0; i < W; i++) begin
        exp_q[0].push_back('{sout: d[i],       last: (i == W - 1), stamp: cyc + int'(i)});
        exp_q[1].push_back('{sout: d[W-1-i],   last: (i == W - 1), stamp: cyc + int'(i)});
      end
      rem = W;
    end else if (rem > 0) begin
      rem--;
    end
    #1;
  endtask

  task automatic mon_one(input int k, input logic s, input logic v, input logic la, input logic rd);
    string tag;
    exp_t  e;
    tag = (k == 0) ? "lsb" : "msb";
    if (exp_q[k].size() > 0 && exp_q[k][0].stamp == cyc) begin
      e = exp_q[k].pop_front();
      check({tag, "_valid"}, {31'd0, v},  32'd1);
      check({tag, "_sout"},  {31'd0, s},  {31'd0, e.sout});
      check({tag, "_last"},  {31'd0, la}, {31'd0, e.last});
      check({tag, "_ready"}, {31'd0, rd}, {31'd0, e.last});
    end else begin
      check({tag, "_idle_valid"}, {31'd0, v},  32'd0);
      check({tag, "_idle_sout"},  {31'd0, s},  32'd0);
      check({tag, "_idle_last"},  {31'd0, la}, 32'd0);
      check({tag, "_idle_ready"}, {31'd0, rd}, 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(0, sout_l, valid_l, last_l, ready_l);
      mon_one(1, sout_m, valid_m, last_m, ready_m);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    D    = '0;
    drive(1'b1, 1'b0, '0);
    mon_en = 1'b1;
    drive(1'b1, 1'b0, '0);
    idle(2);

    // Single frame, D changing while in flight
    drive(1'b0, 1'b1, 4'b1011);
    idle(6);

    // Back-to-back frames: second load during last-bit cycle
    drive(1'b0, 1'b1, 4'hA);
    idle(3);
    drive(1'b0, 1'b1, 4'h5);
    idle(6);

    // Load during bit 2 is ignored
    drive(1'b0, 1'b1, 4'h0);
    idle(1);
    drive(1'b0, 1'b1, 4'hF);
    idle(6);

    // Reset during bit 2, then a fresh frame
    drive(1'b0, 1'b1, 4'hF);
    idle(1);
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'h3);
    idle(6);

    // Reset has priority over load
    drive(1'b1, 1'b1, 4'h9);
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, W'($urandom));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_4bit_tx.md
PISO_4BIT_TX -- requirements
Module: piso_4bit_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (minimum 2).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 sends bit 0 first, 0 sends bit WIDTH-1 first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 D  input  WIDTH  parallel word to transmit, sampled only on an accepted load.
REQ-006 load  input  1  request to start a frame with D.
REQ-007 ready  output  1  block can accept load this cycle.
REQ-008 sout  output  1  serial data bit, registered.
REQ-009 sout_valid  output  1  sout carries a frame bit this cycle, registered.
REQ-010 last  output  1  current sout bit is the final bit of the frame, registered.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and SHIFT.
REQ-012 A load is accepted on a rising edge where load=1 and ready=1; otherwise load SHALL be ignored.
REQ-013 ready SHALL be combinational: 1 in IDLE, 1 in SHIFT only while last=1, else 0.
REQ-014 On acceptance, D SHALL be captured into the shift register, the bit counter set to 0, and the FSM SHALL enter or stay in SHIFT.
REQ-015 Latency: the first frame bit SHALL appear on sout, with sout_valid=1, in the cycle after the accepting edge.
REQ-016 In SHIFT, one bit per cycle SHALL be presented for exactly WIDTH consecutive cycles, in the order set by LSB_FIRST.
REQ-017 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL increment once per SHIFT cycle from 0 to WIDTH-1.
REQ-018 last SHALL be 1 only in the cycle where the counter equals WIDTH-1.
REQ-019 After the last bit with no new load, the FSM SHALL return to IDLE, and sout, sout_valid, and last SHALL be 0 in the next cycle.
REQ-020 For back-to-back frames, a load accepted during the last-bit cycle SHALL start the next frame in the following cycle, with no idle gap and no bit lost or repeated.
REQ-021 A change on D after acceptance SHALL NOT affect the frame in flight.
REQ-022 In IDLE, sout SHALL be 0.

Reset
REQ-023 When rst=1 at a rising edge, the following SHALL hold from the next cycle: FSM=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, last=0, ready=1.
REQ-024 rst SHALL take priority over load; a load in the same cycle as rst SHALL be discarded.
REQ-025 rst asserted mid-frame SHALL abort the frame immediately, with no remaining bits emitted.

Structure
REQ-026 Shared package piso_pkg SHALL hold the state encoding (IDLE=0, SHIFT=1), the WIDTH default, and the counter-width constant function.
REQ-027 The shift register SHALL be built from WIDTH instances of sub-module piso_bit_cell.
REQ-028 Each piso_bit_cell SHALL be a flop with synchronous reset and a three-way next-value select: hold, parallel load, or shift-in from its neighbour.
REQ-029 Bit-cell select lines and the FSM/counter SHALL reside in piso_4bit_tx.

Verification
REQ-030 Single frame: reset, then load=1 with D=4'b1011 for one cycle -> next 4 cycles sout=1,1,0,1, sout_valid=1 each cycle, last=1 on 4th bit only, ready=0 on bits 1-3.
REQ-031 MSB-first: LSB_FIRST=0, D=4'b1011 -> sout=1,0,1,1.
REQ-032 Back-to-back: load D=4'hA, then load D=4'h5 during the last-bit cycle -> 8 contiguous valid bits 0,1,0,1,1,0,1,0 with last on bits 4 and 8.
REQ-033 Ignored load: load D=4'hF during bit 2 of a frame of D=4'h0 -> output stays 0,0,0,0, then IDLE; 4'hF is never sent.
REQ-034 Reset mid-frame: rst=1 during bit 2 of D=4'hF -> next cycle sout=0, sout_valid=0, last=0, ready=1; a subsequent load of 4'h3 sends 1,1,0,0.
REQ-035 Reset priority: rst=1 and load=1 in the same cycle with D=4'h9 -> no valid bits follow and ready=1.
